// File: rtl/gbn_receiver.sv
// Go-Back-N receiver: SYN/data/FIN handshake, in-order payload delivery,
// cumulative ACK generation and idle-timeout teardown.
module gbn_receiver #(
  parameter logic [29:0] IDLE_MAX = 30'd325_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pktvalid,
  input  logic [31:0] SEQin,
  input  logic [8:0]  flagsin,
  input  logic [31:0] datain,
  input  logic        crcok,
  input  logic        ackdone,
  output logic        ackreq,
  output logic [31:0] ACKout,
  output logic [8:0]  flagsout,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] rxcount,
  output logic [15:0] dropcount,
  output logic        done,
  output logic [2:0]  statedisplay
);

  localparam logic [2:0] S_LISTEN  = 3'd0;
  localparam logic [2:0] S_SYNRCVD = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_ACKWAIT = 3'd3;
  localparam logic [2:0] S_FINACK  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [8:0] F_SYNACK = 9'h012;
  localparam logic [8:0] F_ACK    = 9'h010;
  localparam logic [8:0] F_ACKFIN = 9'h011;

  logic [2:0]  r_state;
  logic [31:0] r_peer;
  logic [31:0] r_exp;
  logic [29:0] r_idle;
  logic        r_ackreq;
  logic [8:0]  r_flags;
  logic        r_wr_en;
  logic [15:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [15:0] r_rx;
  logic [15:0] r_drop;

  logic        w_good;
  logic        w_bad;
  logic        w_syn;
  logic        w_fin;
  logic        w_ack;
  logic        w_data;
  logic        w_finpkt;
  logic        w_synpkt;
  logic        w_inseq;
  logic [31:0] w_exp_inc;
  logic [15:0] w_drop_inc;
  logic [29:0] w_idle_inc;
  logic [15:0] w_off;
  logic        w_unused;

  assign w_good     = pktvalid & crcok;
  assign w_bad      = pktvalid & ~crcok;
  assign w_syn      = flagsin[1];
  assign w_fin      = flagsin[0];
  assign w_ack      = flagsin[4];
  assign w_data     = w_good & ~w_syn & ~w_fin;
  assign w_finpkt   = w_good & ~w_syn & w_fin;
  assign w_synpkt   = w_good & w_syn & ~w_ack;
  assign w_inseq    = (SEQin == r_exp);
  assign w_exp_inc  = r_exp + 32'd1;
  assign w_idle_inc = r_idle + 30'd1;
  assign w_off      = SEQin[15:0] - r_peer[15:0] - 16'd1;
  assign w_drop_inc = (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
  assign w_unused   = ^{flagsin[8:5], flagsin[3:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LISTEN;
      r_peer    <= '0;
      r_exp     <= '0;
      r_idle    <= '0;
      r_ackreq  <= 1'b0;
      r_flags   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rx      <= '0;
      r_drop    <= '0;
    end else begin
      r_ackreq <= 1'b0;
      r_wr_en  <= 1'b0;
      if (!enable) begin
        r_state <= S_LISTEN;
      end else begin
        if (w_good) r_idle <= '0;
        if (w_bad)  r_drop <= w_drop_inc;
        case (r_state)
          S_LISTEN: begin
            if (w_synpkt) begin
              r_peer   <= SEQin;
              r_exp    <= SEQin + 32'd1;
              r_rx     <= '0;
              r_drop   <= '0;
              r_idle   <= '0;
              r_flags  <= F_SYNACK;
              r_ackreq <= 1'b1;
              r_state  <= S_SYNRCVD;
            end
          end
          S_SYNRCVD: begin
            if (ackdone) begin
              r_state <= S_OPEN;
            end else if (w_synpkt && SEQin == r_peer) begin
              r_flags  <= F_SYNACK;
              r_ackreq <= 1'b1;
            end
          end
          S_OPEN, S_ACKWAIT: begin
            if (w_data) begin
              r_flags <= F_ACK;
              if (w_inseq) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_off;
                r_wr_data <= datain;
                r_exp     <= w_exp_inc;
                r_rx      <= r_rx + 16'd1;
              end else begin
                r_drop <= w_drop_inc;
              end
              // an ACK already in flight is simply refreshed, not re-requested
              if (r_state == S_OPEN || ackdone) r_ackreq <= 1'b1;
              r_state <= S_ACKWAIT;
            end else if (w_finpkt && w_inseq) begin
              r_exp    <= w_exp_inc;
              r_flags  <= F_ACKFIN;
              r_ackreq <= 1'b1;
              r_state  <= S_FINACK;
            end else begin
              if (w_finpkt) r_drop <= w_drop_inc;
              if (r_state == S_ACKWAIT) begin
                if (ackdone) r_state <= S_OPEN;
              end else if (!w_good) begin
                r_idle <= w_idle_inc;
                if (w_idle_inc >= IDLE_MAX) r_state <= S_LISTEN;
              end
            end
          end
          S_FINACK: begin
            if (ackdone) begin
              r_state <= S_DONE;
            end else if (w_finpkt && SEQin == r_exp - 32'd1) begin
              r_ackreq <= 1'b1;
            end
          end
          S_DONE: r_state <= S_DONE;
          default: r_state <= S_LISTEN;
        endcase
      end
    end
  end

  assign ackreq       = r_ackreq;
  assign ACKout       = r_exp;
  assign flagsout     = r_flags;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign rxcount      = r_rx;
  assign dropcount    = r_drop;
  assign done         = (r_state == S_DONE);
  assign statedisplay = r_state;

endmodule

// File: tb/tb_gbn_receiver.sv
// Scoreboard bench for gbn_receiver: directed handshake scenarios followed
// by randomized traffic against a transaction-level receiver model.
module tb_gbn_receiver;

  localparam int IMAX = 50;
  localparam int L  = 0;
  localparam int SR = 1;
  localparam int OP = 2;
  localparam int AW = 3;
  localparam int FA = 4;
  localparam int DN = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pktvalid = 1'b0;
  logic [31:0] SEQin = '0;
  logic [8:0]  flagsin = '0;
  logic [31:0] datain = '0;
  logic        crcok = 1'b0;
  logic        ackdone = 1'b0;
  logic        ackreq;
  logic [31:0] ACKout;
  logic [8:0]  flagsout;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] rxcount;
  logic [15:0] dropcount;
  logic        done;
  logic [2:0]  statedisplay;

  gbn_receiver #(.IDLE_MAX(30'(IMAX))) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pktvalid(pktvalid), .SEQin(SEQin), .flagsin(flagsin),
    .datain(datain), .crcok(crcok), .ackdone(ackdone),
    .ackreq(ackreq), .ACKout(ACKout), .flagsout(flagsout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rxcount(rxcount), .dropcount(dropcount), .done(done),
    .statedisplay(statedisplay)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned t;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  typedef struct {
    int unsigned t;
    int          st;
    logic [31:0] ack;
    logic [8:0]  fl;
    logic [15:0] rx;
    logic [15:0] drop;
  } snap_t;

  ev_t   wq[$];
  ev_t   aq[$];
  snap_t sq[$];

  // connection as seen from the specification
  int          m_st;
  logic [31:0] m_peer;
  logic [31:0] m_exp;
  logic [8:0]  m_fl;
  logic [15:0] m_rx;
  logic [15:0] m_drop;
  int          m_idle;

  function automatic logic [15:0] sat1(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_st = L; m_peer = 0; m_exp = 0; m_fl = 0;
    m_rx = 0; m_drop = 0; m_idle = 0;
    wq.delete(); aq.delete(); sq.delete();
  endtask

  task automatic reply(input int unsigned t, input logic [8:0] f);
    m_fl = f;
    aq.push_back('{t: t, a: m_exp, b: 32'(f)});
  endtask

  task automatic model(input logic en, input logic pv,
                       input logic [31:0] seq, input logic [8:0] fl,
                       input logic [31:0] d, input logic crc,
                       input logic ad);
    int unsigned t;
    bit good, syn, fin, ackf, isdata, isfin, hit;
    int st0;
    t = cyc + 1;
    good = pv && crc;
    syn = fl[1]; fin = fl[0]; ackf = fl[4];
    isdata = good && !syn && !fin;
    isfin = good && !syn && fin;
    hit = (seq == m_exp);
    st0 = m_st;
    if (!en) begin
      m_st = L;
    end else begin
      if (pv && !crc) m_drop = sat1(m_drop);
      if (good) m_idle = 0;
      if (st0 == L && good && syn && !ackf) begin
        m_peer = seq; m_exp = seq + 1;
        m_rx = 0; m_drop = 0; m_idle = 0;
        reply(t, 9'h012);
        m_st = SR;
      end else if (st0 == SR) begin
        if (ad) m_st = OP;
        else if (good && syn && !ackf && seq == m_peer)
          reply(t, 9'h012);
      end else if ((st0 == OP || st0 == AW) && isdata) begin
        if (hit) begin
          wq.push_back('{t: t, a: 32'(16'(seq - m_peer - 1)), b: d});
          m_exp = m_exp + 1;
          m_rx = m_rx + 1;
        end else begin
          m_drop = sat1(m_drop);
        end
        m_fl = 9'h010;
        if (st0 == OP || ad) reply(t, 9'h010);
        m_st = AW;
      end else if ((st0 == OP || st0 == AW) && isfin && hit) begin
        m_exp = m_exp + 1;
        reply(t, 9'h011);
        m_st = FA;
      end else if (st0 == OP || st0 == AW) begin
        if (isfin) m_drop = sat1(m_drop);
        if (st0 == AW && ad) m_st = OP;
        if (st0 == OP && !good) begin
          m_idle++;
          if (m_idle >= IMAX) m_st = L;
        end
      end else if (st0 == FA) begin
        if (ad) m_st = DN;
        else if (isfin && seq == m_exp - 1) reply(t, m_fl);
      end
    end
    sq.push_back('{t: t, st: m_st, ack: m_exp, fl: m_fl,
                   rx: m_rx, drop: m_drop});
  endtask

  task automatic step(input logic en, input logic pv,
                      input logic [31:0] seq, input logic [8:0] fl,
                      input logic [31:0] d, input logic crc,
                      input logic ad);
    @(posedge clk);
    #1;
    enable = en; pktvalid = pv; SEQin = seq; flagsin = fl;
    datain = d; crcok = crc; ackdone = ad;
    model(en, pv, seq, fl, d, crc, ad);
  endtask

  task automatic pkt(input logic [31:0] seq, input logic [8:0] fl,
                     input logic [31:0] d);
    step(1'b1, 1'b1, seq, fl, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 32'd0, 9'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic ackd();
    step(1'b1, 1'b0, 32'd0, 9'd0, 32'd0, 1'b1, 1'b1);
  endtask

  // one more cycle, then observe the result of the previous stimulus
  task automatic look();
    idle(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    enable = 1'b1; pktvalid = 1'b0; SEQin = '0; flagsin = '0;
    datain = '0; crcok = 1'b1; ackdone = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_wr_en", 32'(wr_en), 0);
    chk("rst_async_ackreq", 32'(ackreq), 0);
    chk("rst_async_state", 32'(statedisplay), 0);
    @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_ACKout", ACKout, 0);
    chk("rst_flagsout", 32'(flagsout), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rxcount", 32'(rxcount), 0);
    chk("rst_dropcount", 32'(dropcount), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model(1'b1, 1'b0, 32'd0, 9'd0, 32'd0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wq.size() > 0 && wq[0].t == cyc) begin
        ev_t e;
        e = wq.pop_front();
        chk("wr_en", 32'(wr_en), 1);
        chk("wr_addr", 32'(wr_addr), e.a);
        chk("wr_data", wr_data, e.b);
      end else if (wr_en) begin
        chk("wr_en_unexpected", 32'(wr_en), 0);
      end
      if (aq.size() > 0 && aq[0].t == cyc) begin
        ev_t e;
        e = aq.pop_front();
        chk("ackreq", 32'(ackreq), 1);
        chk("ack_ACKout", ACKout, e.a);
        chk("ack_flagsout", 32'(flagsout), e.b);
      end else if (ackreq) begin
        chk("ackreq_unexpected", 32'(ackreq), 0);
      end
      while (sq.size() > 0 && sq[0].t < cyc) void'(sq.pop_front());
      if (sq.size() > 0 && sq[0].t == cyc) begin
        snap_t s;
        s = sq.pop_front();
        chk("state", 32'(statedisplay), 32'(s.st));
        chk("ACKout", ACKout, s.ack);
        chk("flagsout", 32'(flagsout), 32'(s.fl));
        chk("rxcount", 32'(rxcount), 32'(s.rx));
        chk("dropcount", 32'(dropcount), 32'(s.drop));
        chk("done", 32'(done), 32'(s.st == DN));
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // handshake from ISN 100
    pkt(32'd100, 9'h002, 32'd0);
    look();
    chk("syn_ackreq", 32'(ackreq), 1);
    chk("syn_flags", 32'(flagsout), 32'h012);
    chk("syn_ACKout", ACKout, 32'd101);
    chk("syn_state", 32'(statedisplay), 1);
    ackd();
    look();
    chk("open_state", 32'(statedisplay), 2);

    // out-of-order packet
    pkt(32'd103, 9'h000, 32'hDEAD0003);
    look();
    chk("ooo_wr_en", 32'(wr_en), 0);
    chk("ooo_drop", 32'(dropcount), 1);
    chk("ooo_ackreq", 32'(ackreq), 1);
    chk("ooo_ACKout", ACKout, 32'd101);
    ackd();

    pkt(32'd101, 9'h000, 32'hA0A0A0A0);
    look();
    chk("d101_wr_en", 32'(wr_en), 1);
    chk("d101_addr", 32'(wr_addr), 0);
    chk("d101_data", wr_data, 32'hA0A0A0A0);
    chk("d101_state", 32'(statedisplay), 3);

    // data together with ackdone while waiting
    step(1'b1, 1'b1, 32'd102, 9'h010, 32'hA1A1A1A1, 1'b1, 1'b1);
    look();
    chk("d102_wr_en", 32'(wr_en), 1);
    chk("d102_addr", 32'(wr_addr), 1);
    chk("d102_ackreq", 32'(ackreq), 1);
    chk("d102_state", 32'(statedisplay), 3);
    ackd();
    pkt(32'd103, 9'h000, 32'hA2A2A2A2);
    look();
    chk("d103_addr", 32'(wr_addr), 2);
    ackd();
    look();
    chk("seq_ACKout", ACKout, 32'd104);
    chk("seq_rx", 32'(rxcount), 3);
    chk("seq_state", 32'(statedisplay), 2);

    // close
    pkt(32'd104, 9'h001, 32'd0);
    look();
    chk("fin_flags", 32'(flagsout), 32'h011);
    chk("fin_ACKout", ACKout, 32'd105);
    chk("fin_state", 32'(statedisplay), 4);
    ackd();
    look();
    chk("done_hi", 32'(done), 1);
    chk("done_state", 32'(statedisplay), 5);
    step(1'b0, 1'b0, 32'd0, 9'd0, 32'd0, 1'b1, 1'b0);
    look();
    chk("dis_state", 32'(statedisplay), 0);
    chk("dis_done", 32'(done), 0);
    chk("dis_rx_held", 32'(rxcount), 3);

    // sequence-number wrap
    pkt(32'hFFFF_FFFE, 9'h002, 32'd0);
    ackd();
    pkt(32'hFFFF_FFFF, 9'h000, 32'hB0B0B0B0);
    look();
    chk("wrap0_addr", 32'(wr_addr), 0);
    ackd();
    pkt(32'h0000_0000, 9'h000, 32'hB1B1B1B1);
    look();
    chk("wrap1_addr", 32'(wr_addr), 1);
    chk("wrap1_data", wr_data, 32'hB1B1B1B1);
    ackd();
    look();
    chk("wrap_ACKout", ACKout, 32'd1);
    chk("wrap_rx", 32'(rxcount), 2);

    // bad checksum and stray FIN both count as drops
    step(1'b1, 1'b1, 32'd1, 9'h000, 32'd7, 1'b0, 1'b0);
    look();
    chk("crc_drop", 32'(dropcount), 1);
    chk("crc_wr_en", 32'(wr_en), 0);
    pkt(32'd5, 9'h001, 32'd0);
    look();
    chk("finx_drop", 32'(dropcount), 2);
    chk("finx_state", 32'(statedisplay), 2);

    // idle timeout
    idle(40);
    @(negedge clk);
    chk("idle_open", 32'(statedisplay), 2);
    idle(15);
    @(negedge clk);
    chk("idle_listen", 32'(statedisplay), 0);

    // reset in the middle of a transfer
    pkt(32'd7, 9'h002, 32'd0);
    ackd();
    pkt(32'd8, 9'h000, 32'hC0C0C0C0);
    do_reset();
    pkt(32'd9, 9'h000, 32'hC1C1C1C1);
    look();
    chk("postrst_state", 32'(statedisplay), 0);
    chk("postrst_wr_en", 32'(wr_en), 0);
    pkt(32'd50, 9'h012, 32'd0);
    look();
    chk("synack_ignored", 32'(statedisplay), 0);
    chk("synack_noack", 32'(ackreq), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic en, pv, crc, ad;
      logic [31:0] seq, d;
      logic [8:0] fl;
      int r;
      en = ($urandom_range(0, 99) < 97);
      pv = ($urandom_range(0, 99) < 45);
      crc = ($urandom_range(0, 99) < 90);
      ad = ($urandom_range(0, 99) < 30);
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r < 5) seq = m_exp;
      else if (r == 5) seq = m_exp + 1;
      else if (r == 6) seq = m_exp - 1;
      else if (r == 7) seq = m_exp + 2;
      else seq = $urandom;
      if (m_st == L) begin
        fl = ($urandom_range(0, 3) != 0) ? 9'h002 : 9'h012;
        if ($urandom_range(0, 1) == 1) seq = $urandom;
        else seq = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else begin
        r = $urandom_range(0, 19);
        if (r < 12) fl = 9'h000;
        else if (r < 14) fl = 9'h010;
        else if (r < 17) fl = 9'h001;
        else if (r < 19) fl = 9'h002;
        else fl = 9'($urandom);
      end
      step(en, pv, seq, fl, d, crc, ad);
    end

    idle(3);
    @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 0);
    chk("aq_drained", 32'(aq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
